// File: rtl/seqgen_tx_if.sv
// Command/serial-output bundle for seqgen_tx: the controller side drives the
// transfer request, the transmitter side returns the serial stream and status.
interface seqgen_tx_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               start;
    logic [1:0]         pat_sel;
    logic [MAX_LEN-1:0] custom_pat;
    logic [LW-1:0]      custom_len;
    logic [3:0]         rpt;
    logic               x;
    logic               valid;
    logic               last;
    logic               busy;
    logic               done;

    modport master (
        output start, pat_sel, custom_pat, custom_len, rpt,
        input  x, valid, last, busy, done
    );

    modport slave (
        input  start, pat_sel, custom_pat, custom_len, rpt,
        output x, valid, last, busy, done
    );
endinterface

// File: rtl/seqgen_tx.sv
// Serial pattern transmitter: sends 0110, 1010, 01101010 or a custom pattern
// MSB first, rpt+1 times. Define SEQGEN_GAP_EN for one idle cycle between repetitions.
module seqgen_tx #(
    parameter int   MAX_LEN  = 16,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic        clk,
    input logic        rst,
    seqgen_tx_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_FIN = 2'd2, S_GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_FIN = 2'd2} state_t;
`endif

    state_t             r_state, w_state_next;
    logic [MAX_LEN-1:0] r_cap, w_cap_next;
    logic [MAX_LEN-1:0] r_shift, w_shift_next;
    logic [LW-1:0]      r_len, w_len_next;
    logic [LW-1:0]      r_bitcnt, w_bitcnt_next;
    logic [3:0]         r_rptcnt, w_rptcnt_next;
    logic               r_x, w_x_next;
    logic               r_valid, w_valid_next;
    logic               r_last, w_last_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;

    logic [MAX_LEN-1:0] w_acc_pat;
    logic [LW-1:0]      w_acc_len;
    logic               w_do_load;
    logic [MAX_LEN-1:0] w_load_pat;
    logic [LW-1:0]      w_load_len;

    // Patterns are stored left-aligned so the next bit is always the MSB.
    always_comb begin
        w_acc_pat = '0;
        w_acc_len = '0;
        case (bus.pat_sel)
            2'b00: begin
                w_acc_pat = {4'b0110, {(MAX_LEN-4){1'b0}}};
                w_acc_len = LW'(4);
            end
            2'b01: begin
                w_acc_pat = {4'b1010, {(MAX_LEN-4){1'b0}}};
                w_acc_len = LW'(4);
            end
            2'b11: begin
                w_acc_pat = {8'b01101010, {(MAX_LEN-8){1'b0}}};
                w_acc_len = LW'(8);
            end
            default: begin
                w_acc_len = (bus.custom_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.custom_len;
                w_acc_pat = bus.custom_pat << (LW'(MAX_LEN) - w_acc_len);
            end
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_cap_next    = r_cap;
        w_shift_next  = r_shift;
        w_len_next    = r_len;
        w_bitcnt_next = r_bitcnt;
        w_rptcnt_next = r_rptcnt;
        w_x_next      = IDLE_BIT;
        w_valid_next  = 1'b0;
        w_last_next   = 1'b0;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;
        w_do_load     = 1'b0;
        w_load_pat    = r_cap;
        w_load_len    = r_len;

        case (r_state)
            S_IDLE, S_FIN: begin
                w_state_next = S_IDLE;
                if (bus.start) begin
                    w_cap_next    = w_acc_pat;
                    w_len_next    = w_acc_len;
                    w_rptcnt_next = bus.rpt;
                    if (w_acc_len == '0) begin
                        w_state_next = S_FIN;
                        w_done_next  = 1'b1;
                    end else begin
                        w_do_load  = 1'b1;
                        w_load_pat = w_acc_pat;
                        w_load_len = w_acc_len;
                    end
                end
            end
            S_SEND: begin
                if (r_bitcnt != '0) begin
                    w_x_next      = r_shift[MAX_LEN-1];
                    w_shift_next  = r_shift << 1;
                    w_bitcnt_next = r_bitcnt - LW'(1);
                    w_last_next   = (r_bitcnt == LW'(1));
                    w_valid_next  = 1'b1;
                    w_busy_next   = 1'b1;
                end else if (r_rptcnt != 4'd0) begin
                    w_rptcnt_next = r_rptcnt - 4'd1;
`ifdef SEQGEN_GAP_EN
                    w_state_next  = S_GAP;
                    w_busy_next   = 1'b1;
`else
                    w_do_load     = 1'b1;
`endif
                end else begin
                    w_state_next = S_FIN;
                    w_done_next  = 1'b1;
                end
            end
`ifdef SEQGEN_GAP_EN
            S_GAP: w_do_load = 1'b1;
`endif
            default: w_state_next = S_IDLE;
        endcase

        // Start of a repetition: first bit goes straight to the output register.
        if (w_do_load) begin
            w_state_next  = S_SEND;
            w_x_next      = w_load_pat[MAX_LEN-1];
            w_shift_next  = w_load_pat << 1;
            w_bitcnt_next = w_load_len - LW'(1);
            w_last_next   = (w_load_len == LW'(1));
            w_valid_next  = 1'b1;
            w_busy_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cap    <= '0;
            r_shift  <= '0;
            r_len    <= '0;
            r_bitcnt <= '0;
            r_rptcnt <= '0;
            r_x      <= IDLE_BIT;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cap    <= w_cap_next;
            r_shift  <= w_shift_next;
            r_len    <= w_len_next;
            r_bitcnt <= w_bitcnt_next;
            r_rptcnt <= w_rptcnt_next;
            r_x      <= w_x_next;
            r_valid  <= w_valid_next;
            r_last   <= w_last_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.x     = r_x;
    assign bus.valid = r_valid;
    assign bus.last  = r_last;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: doc/seqgen_tx.md
Name: seqgen_tx

Overview:
Serial bit-pattern transmitter that drives the single-bit serial input of the sequence-detector blocks, one bit per clock. It emits the built-in patterns 0110 and 1010, their concatenation, or a programmable custom pattern, repeated a requested number of times. Transfers are started with a start/busy handshake, and the block signals completion with a one-cycle done pulse. It is used as the stimulus source in front of detector blocks in system-level benches and in loopback tests.

Parameters:
MAX_LEN, 16, maximum custom pattern length in bits (must be ≥ 8).
IDLE_BIT, 1'b0, value driven on x whenever valid = 0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; rst = 0 clears all state immediately.
start  input  1  request a transfer; accepted only while busy = 0.
pat_sel  input  2  pattern select: 00 = 0110, 01 = 1010, 10 = custom, 11 = 01101010.
custom_pat  input  MAX_LEN  custom pattern bits; bit [len-1] is sent first.
custom_len  input  $clog2(MAX_LEN+1)  custom pattern length in bits.
rpt  input  4  repetition count minus one; the pattern is sent rpt+1 times.
x  output  1  serial data out.
valid  output  1  x carries a pattern bit this cycle.
last  output  1  high on the final bit of each pattern instance.
busy  output  1  transfer in progress; start is ignored while high.
done  output  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset (rst = 0, asynchronous): x = IDLE_BIT, valid = 0, last = 0, busy = 0, done = 0, FSM = IDLE.
  - All counters and shift registers are cleared.
  - Reset asserted mid-transfer aborts the transfer with no done pulse.
- All outputs are registered.
- FSM states: IDLE, SEND, FIN.
- IDLE:
  - Default outputs: busy = 0, valid = 0, x = IDLE_BIT.
  - On an edge with start = 1, pat_sel, custom_pat, custom_len and rpt are captured; later input changes have no effect until the next accepted start.
  - If the effective length ≥ 1, the FSM goes to SEND.
  - If the effective length = 0, the FSM goes to FIN directly: no bits are sent, busy is high for zero cycles, done pulses on the following cycle.
- Effective length:
  - Built-in patterns: 4, 4 or 8.
  - Custom: custom_len clamped to MAX_LEN.
- Latency: the first bit appears on x with valid = 1 and busy = 1 immediately after the accepting edge (zero-cycle latency).
- SEND:
  - One bit per cycle, MSB first, from a shift register reloaded from the captured pattern at the start of each repetition.
  - Repetitions are back-to-back with no idle bit, unless the optional feature below is enabled.
  - A bit counter runs from len-1 down to 0; last = 1 when the counter = 0.
  - A repetition counter runs from rpt down to 0. The FSM leaves SEND after the last bit of the final repetition.
- Total valid cycles = len × (rpt+1).
- FIN: exactly one cycle with done = 1, busy = 0, valid = 0, x = IDLE_BIT. The FSM then returns to IDLE.
- A start asserted during FIN is accepted, because busy = 0. This allows the next transfer to follow with exactly one idle cycle between frames.
- start asserted while busy = 1 is ignored and is not queued.
- pat_sel = 10 with custom_len > MAX_LEN: the pattern is sent as custom_pat[MAX_LEN-1:0].

Optional Feature:
- Macro: SEQGEN_GAP_EN.
- When defined:
  - One idle cycle (valid = 0, x = IDLE_BIT, busy = 1) is inserted between consecutive repetitions, through an extra FSM state GAP.
  - Total busy cycles = len × (rpt+1) + rpt.
- When undefined:
  - The GAP state and its logic are absent.
  - Repetitions are contiguous.

Test Plan:
- Reset, then start with pat_sel = 00, rpt = 0 → x = 0,1,1,0 on 4 consecutive valid cycles; last on the 4th; done pulses on the 5th cycle; busy low after that.
- Start with pat_sel = 01, rpt = 2 → 12 valid cycles: x = 1010 1010 1010; last on cycles 4, 8 and 12; exactly one done pulse. With SEQGEN_GAP_EN defined, the bench instead checks 14 busy cycles containing 2 idle bits.
- Start with pat_sel = 10, custom_pat = 16'h00B6, custom_len = 7 → x = 0110110 (7 bits, MSB first); pat_sel changed mid-frame has no effect on the frame in progress.
- Start pulsed again while busy → ignored, no second frame. Start during the done cycle → new frame begins on the next cycle.
- rst driven low at bit 2 of a pat_sel = 11 frame → outputs cleared immediately without waiting for a clock edge; no done pulse; the next start restarts from the first bit, 0.
- custom_len = 0 → no valid cycles, done pulses 1 cycle after acceptance. custom_len = 20 → exactly 16 bits sent.
